psum_drain: RTL and testbench

Read-side companion to the PE's partial-sum FIFO. Pops one 3×6 psum word whenever the FIFO is non-empty and unpacks it into three output rows of six elements. Each element is requantized (rounding arithmetic right shift, optional ReLU, signed saturation) and handed to the output buffer over a valid/ready handshake. One instance sits beside each PE and is the only reader of that PE's FIFO.

---
 rtl/psum_drain.sv | 157 +++++++++++++++
 tb/tb_psum_drain.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// psum_drain: pops 3x6 psum words from the PE FIFO and emits requantized rows.
// Optional saturation counter enabled by defining PSUM_DRAIN_STAT_EN.
module psum_drain #(
   parameter int PSUM_WIDTH  = 16,
   parameter int OUT_WIDTH   = 8,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fifo_empty_i,
   output logic                       fifo_rd_en_o,
   input  logic [18*PSUM_WIDTH-1:0]   fifo_dout_i,
   input  logic [SHIFT_WIDTH-1:0]     shift_i,
   input  logic                       relu_en_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [6*OUT_WIDTH-1:0]     out_data_o,
   output logic [1:0]                 out_row_o,
   output logic                       out_last_o,
   output logic                       busy_o,
   input  logic                       clr_stat_i,
   output logic [15:0]                sat_cnt_o
);

   localparam int EW = PSUM_WIDTH + 1;
   localparam int RW = 6 * PSUM_WIDTH;
   localparam logic signed [EW-1:0] C_MAX = EW'((2**(OUT_WIDTH-1)) - 1);
   localparam logic signed [EW-1:0] C_MIN = EW'(-(2**(OUT_WIDTH-1)));

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_EMIT
   } state_t;

   state_t                    r_state;
   logic [1:0]                r_row;
   logic [18*PSUM_WIDTH-1:0]  r_word;
   logic [SHIFT_WIDTH-1:0]    r_shift;
   logic                      r_relu;

   logic                      w_valid;
   logic                      w_acc;
   logic [RW-1:0]             w_rw;
   logic [6*OUT_WIDTH-1:0]    w_data;
   logic [5:0]                w_sat;

   assign w_valid = (r_state == S_EMIT);
   assign w_acc   = w_valid && out_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_word  <= '0;
         r_shift <= '0;
         r_relu  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (!fifo_empty_i) r_state <= S_READ;
            end
            S_READ: r_state <= S_LOAD;
            S_LOAD: begin
               r_word  <= fifo_dout_i;
               r_shift <= shift_i;
               r_relu  <= relu_en_i;
               r_row   <= '0;
               r_state <= S_EMIT;
            end
            S_EMIT: begin
               if (w_acc) begin
                  if (r_row == 2'd2) begin
                     r_row   <= '0;
                     r_state <= fifo_empty_i ? S_IDLE : S_READ;
                  end else begin
                     r_row <= r_row + 2'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rw = r_word[2*RW +: RW];
      unique case (r_row)
         2'd0:    w_rw = r_word[0 +: RW];
         2'd1:    w_rw = r_word[RW +: RW];
         default: w_rw = r_word[2*RW +: RW];
      endcase
   end

   // Round-half-up shift, ReLU, then clamp; all in PSUM_WIDTH+1 bits.
   for (genvar c = 0; c < 6; c++) begin : g_col
      logic [PSUM_WIDTH-1:0]    w_e;
      logic signed [EW-1:0]     w_x;
      logic signed [EW-1:0]     w_rnd;
      logic signed [EW-1:0]     w_sh;
      logic signed [EW-1:0]     w_rl;
      logic                     w_hi;
      logic                     w_lo;

      assign w_e   = w_rw[c*PSUM_WIDTH +: PSUM_WIDTH];
      assign w_x   = {w_e[PSUM_WIDTH-1], w_e};
      assign w_rnd = (r_shift == '0) ? '0
                   : (EW'(1) << (r_shift - 1'b1));
      assign w_sh  = (w_x + w_rnd) >>> r_shift;
      assign w_rl  = (r_relu && w_sh[EW-1]) ? '0 : w_sh;
      assign w_hi  = (w_rl > C_MAX);
      assign w_lo  = (w_rl < C_MIN);
      assign w_sat[c] = w_hi | w_lo;
      assign w_data[c*OUT_WIDTH +: OUT_WIDTH] =
         w_hi ? C_MAX[OUT_WIDTH-1:0] :
         w_lo ? C_MIN[OUT_WIDTH-1:0] : w_rl[OUT_WIDTH-1:0];
   end

   assign fifo_rd_en_o = (r_state == S_READ);
   assign out_valid_o  = w_valid;
   assign out_data_o   = w_valid ? w_data : '0;
   assign out_row_o    = w_valid ? r_row : 2'd0;
   assign out_last_o   = w_valid && (r_row == 2'd2);
   assign busy_o       = (r_state != S_IDLE);

`ifdef PSUM_DRAIN_STAT_EN
   logic [15:0] r_sat_cnt;
   logic [2:0]  w_nsat;
   logic [16:0] w_sum;

   always_comb begin
      w_nsat = '0;
      for (int c = 0; c < 6; c++) w_nsat = w_nsat + 3'(w_sat[c]);
   end

   assign w_sum = {1'b0, r_sat_cnt} + 17'(w_nsat);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sat_cnt <= '0;
      end else if (clr_stat_i) begin
         r_sat_cnt <= '0;
      end else if (w_acc) begin
         r_sat_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      end
   end

   assign sat_cnt_o = r_sat_cnt;
`else
   logic w_unused;

   assign w_unused  = ^{clr_stat_i, w_sat};
   assign sat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scoreboard bench for psum_drain.
// A FIFO model feeds words; expected rows are queued and checked on handshake.
module tb_psum_drain;

   localparam int PW = 16;
   localparam int OW = 8;
   localparam int NSAT = 3700;
`ifdef PSUM_DRAIN_STAT_EN
   localparam int STAT = 1;
`else
   localparam int STAT = 0;
`endif

   typedef struct {
      logic [6*OW-1:0] data;
      logic [1:0]      row;
      int              nsat;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              fifo_empty_i;
   logic              fifo_rd_en_o;
   logic [18*PW-1:0]  fifo_dout_i;
   logic [3:0]        shift_i;
   logic              relu_en_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [6*OW-1:0]   out_data_o;
   logic [1:0]        out_row_o;
   logic              out_last_o;
   logic              busy_o;
   logic              clr_stat_i;
   logic [15:0]       sat_cnt_o;

   logic [18*PW-1:0]  fq[$];
   ent_t              sb[$];
   int                el[18];
   int                passed = 0;
   int                total = 0;
   int                exp_sat = 0;
   int                n;

   always #5 clk = ~clk;

   psum_drain dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty_i (fifo_empty_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .fifo_dout_i  (fifo_dout_i),
      .shift_i      (shift_i),
      .relu_en_i    (relu_en_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_row_o    (out_row_o),
      .out_last_o   (out_last_o),
      .busy_o       (busy_o),
      .clr_stat_i   (clr_stat_i),
      .sat_cnt_o    (sat_cnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rq(input int x, input int s, input bit relu,
                             output bit sat);
      int y;
      y = x;
      if (s > 0) y = (x + (1 << (s - 1))) >>> s;
      if (relu && y < 0) y = 0;
      sat = 1'b0;
      if (y > 127) begin
         y = 127;
         sat = 1'b1;
      end else if (y < -128) begin
         y = -128;
         sat = 1'b1;
      end
      return y;
   endfunction

   task automatic push_word(input int s, input bit relu);
      logic [18*PW-1:0] w;
      ent_t e;
      bit st;
      int y;
      shift_i = 4'(s);
      relu_en_i = relu;
      w = '0;
      for (int i = 0; i < 18; i++) w[i*PW +: PW] = PW'(el[i]);
      fq.push_back(w);
      fifo_empty_i = 1'b0;
      for (int r = 0; r < 3; r++) begin
         e.row = 2'(r);
         e.data = '0;
         e.nsat = 0;
         for (int c = 0; c < 6; c++) begin
            y = rq(el[r*6+c], s, relu, st);
            e.data[c*OW +: OW] = OW'(y);
            e.nsat += int'(st);
         end
         sb.push_back(e);
      end
   endtask

   task automatic monitor();
      ent_t e;
      if (out_valid_o && out_ready_i) begin
         chk("sb_nonempty", 64'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("row_data", 64'(out_data_o), 64'(e.data));
            chk("row_idx", 64'(out_row_o), 64'(e.row));
            chk("row_last", 64'(out_last_o), 64'(e.row == 2'd2));
            chk("sat_cnt", 64'(sat_cnt_o), 64'(exp_sat));
            exp_sat = exp_sat + STAT * e.nsat;
            if (exp_sat > 65535) exp_sat = 65535;
         end
      end else if (!out_valid_o) begin
         chk("idle_out", 64'({out_data_o, out_row_o, out_last_o}), 0);
      end
   endtask

   task automatic tick();
      logic rd;
      @(negedge clk);
      monitor();
      if (clr_stat_i || rst) exp_sat = 0;
      rd = fifo_rd_en_o;
      @(posedge clk);
      #1;
      if (rd) begin
         chk("pop_avail", 64'(fq.size() > 0), 1);
         if (fq.size() > 0) fifo_dout_i = fq.pop_front();
      end
      fifo_empty_i = (fq.size() == 0);
   endtask

   task automatic ticks(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic drain(input int bound, output int cnt);
      cnt = 0;
      while ((busy_o || fq.size() > 0 || sb.size() > 0) && cnt < bound) begin
         tick();
         cnt++;
      end
      chk("drain_done", 64'(busy_o || fq.size() > 0 || sb.size() > 0), 0);
   endtask

   initial begin
      rst = 1'b1;
      fifo_empty_i = 1'b0;
      fifo_dout_i = '0;
      shift_i = '0;
      relu_en_i = 1'b0;
      out_ready_i = 1'b1;
      clr_stat_i = 1'b0;

      // reset held with a non-empty FIFO flag
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_rd_en", 64'(fifo_rd_en_o), 0);
         chk("rst_valid", 64'(out_valid_o), 0);
         chk("rst_sat", 64'(sat_cnt_o), 0);
         chk("rst_outs", 64'({out_data_o, out_row_o, out_last_o, busy_o}), 0);
      end
      fifo_empty_i = 1'b1;
      rst = 1'b0;
      tick();

      // single word, latency and row contents
      for (int i = 0; i < 18; i++) el[i] = i - 9;
      push_word(0, 1'b0);
      tick();
      chk("lat_rd_c1", 64'(fifo_rd_en_o), 1);
      tick();
      chk("lat_rd_c2", 64'(fifo_rd_en_o), 0);
      chk("lat_val_c2", 64'(out_valid_o), 0);
      chk("lat_busy_c2", 64'(busy_o), 1);
      tick();
      chk("lat_val_c3", 64'(out_valid_o), 1);
      chk("lat_row_c3", 64'(out_row_o), 0);
      chk("lat_last_c3", 64'(out_last_o), 0);
      chk("r0c0", 64'(out_data_o[7:0]), 64'(8'hF7));
      tick();
      chk("lat_last_c4", 64'(out_last_o), 0);
      tick();
      chk("lat_last_c5", 64'(out_last_o), 1);
      chk("r2c5", 64'(out_data_o[47:40]), 8);
      tick();
      chk("idle_busy", 64'(busy_o), 0);
      chk("idle_valid", 64'(out_valid_o), 0);

      // rounding and saturation, shift 2
      for (int i = 0; i < 18; i++) el[i] = 0;
      el[0] = 384;
      el[1] = 383;
      el[2] = 1000;
      el[3] = -1000;
      el[4] = -2;
      push_word(2, 1'b0);
      ticks(3);
      chk("rnd_384", 64'(out_data_o[7:0]), 96);
      chk("rnd_383", 64'(out_data_o[15:8]), 96);
      chk("sat_hi", 64'(out_data_o[23:16]), 127);
      chk("sat_lo", 64'(out_data_o[31:24]), 64'(8'h80));
      chk("rnd_m2", 64'(out_data_o[39:32]), 0);
      drain(50, n);
      chk("sat_after_rnd", 64'(sat_cnt_o), 64'(2 * STAT));

      // ReLU, shift 0
      for (int i = 0; i < 18; i++) el[i] = 0;
      el[0] = -5;
      el[1] = 5;
      el[2] = 200;
      push_word(0, 1'b1);
      ticks(3);
      chk("relu_m5", 64'(out_data_o[7:0]), 0);
      chk("relu_5", 64'(out_data_o[15:8]), 5);
      chk("relu_200", 64'(out_data_o[23:16]), 127);
      drain(50, n);
      chk("sat_after_relu", 64'(sat_cnt_o), 64'(3 * STAT));

      // backpressure on row 1, with a second word waiting
      for (int i = 0; i < 18; i++) el[i] = i * 37 - 300;
      push_word(1, 1'b0);
      ticks(4);
      out_ready_i = 1'b0;
      for (int i = 0; i < 18; i++) el[i] = i * 5 - 40;
      push_word(3, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid", 64'(out_valid_o), 1);
         chk("bp_row", 64'(out_row_o), 1);
         chk("bp_data", 64'(out_data_o), 64'(sb[0].data));
         chk("bp_no_pop", 64'(fifo_rd_en_o), 0);
         tick();
      end
      out_ready_i = 1'b1;
      tick();
      chk("bp_row2", 64'(out_row_o), 2);
      drain(50, n);

      // back-to-back saturating words: throughput and counter ceiling
      for (int i = 0; i < 18; i++) el[i] = 1000;
      for (int k = 0; k < NSAT; k++) push_word(0, 1'b0);
      drain(5 * NSAT + 100, n);
      chk("throughput", 64'(n), 64'(5 * NSAT + 1));
      chk("sat_ceiling", 64'(sat_cnt_o), 64'(STAT * 65535));

      // clear wins over a same-cycle increment
      push_word(0, 1'b0);
      ticks(3);
      clr_stat_i = 1'b1;
      tick();
      clr_stat_i = 1'b0;
      chk("clr_wins", 64'(sat_cnt_o), 0);
      drain(50, n);
      chk("sat_after_clr", 64'(sat_cnt_o), 64'(12 * STAT));

      // two queued words, then reset during row 1 of the second
      for (int i = 0; i < 18; i++) el[i] = i * 11 - 90;
      push_word(1, 1'b0);
      push_word(1, 1'b0);
      ticks(5);
      chk("q2_rd_c5", 64'(fifo_rd_en_o), 0);
      tick();
      chk("q2_rd_c6", 64'(fifo_rd_en_o), 1);
      ticks(3);
      chk("q2_row1", 64'(out_row_o), 1);
      rst = 1'b1;
      out_ready_i = 1'b0;
      tick();
      chk("mid_rst_outs",
          64'({fifo_rd_en_o, out_valid_o, out_data_o, out_row_o,
               out_last_o, busy_o}), 0);
      chk("mid_rst_sat", 64'(sat_cnt_o), 0);
      sb.delete();
      rst = 1'b0;
      out_ready_i = 1'b1;
      ticks(2);
      chk("post_rst_idle", 64'({busy_o, fifo_rd_en_o}), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
